// File: rtl/util_pkg.sv
// Shared display/ambient-light constants and types used by disp_lux and the
// display PDM dimmer.
package util_pkg;

  localparam int DISP_PDM_W = 8;
  localparam int LUX_CNT_W  = 16;

  typedef logic [DISP_PDM_W-1:0] pdm_t;
  typedef logic [LUX_CNT_W-1:0]  lux_cnt_t;

  localparam pdm_t     PDM_MAX   = {DISP_PDM_W{1'b1}};
  localparam pdm_t     PDM_RESET = pdm_t'(8'h80);
  localparam lux_cnt_t LUX_MAX   = {LUX_CNT_W{1'b1}};

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous pulse train plus a history flop,
// producing a single-cycle strobe on each rising edge.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/disp_lux.sv
// Ambient-light driven display brightness: counts sensor edges over a fixed
// microsecond gate, scales and clamps the count, and slews disp_pdm toward it.
module disp_lux
  import util_pkg::*;
#(
  parameter int GATE_US = 10000,
  parameter int SHIFT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tsc_1ppus,
  input  logic                  lux_in,
  input  logic                  cfg_auto,
  input  logic [DISP_PDM_W-1:0] cfg_manual,
  input  logic [DISP_PDM_W-1:0] cfg_min,
  input  logic [DISP_PDM_W-1:0] cfg_max,
  output logic [DISP_PDM_W-1:0] disp_pdm,
  output logic [LUX_CNT_W-1:0]  lux_cnt,
  output logic                  lux_valid
);

  localparam int              GATE_W    = (GATE_US > 1) ? $clog2(GATE_US) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_US - 1);

  function automatic lux_cnt_t sat_inc(input lux_cnt_t cnt);
    return (cnt == LUX_MAX) ? cnt : cnt + LUX_CNT_W'(1);
  endfunction

  function automatic pdm_t sat_scale(input lux_cnt_t cnt);
    lux_cnt_t scaled;
    scaled = cnt >> SHIFT;
    return (scaled > lux_cnt_t'(PDM_MAX)) ? PDM_MAX : scaled[DISP_PDM_W-1:0];
  endfunction

  // Raising to the floor first then capping means an inverted window
  // (lo > hi) always resolves to hi.
  function automatic pdm_t clamp(input pdm_t val, input pdm_t lo, input pdm_t hi);
    pdm_t t;
    t = (val < lo) ? lo : val;
    t = (t > hi) ? hi : t;
    return t;
  endfunction

  function automatic pdm_t slew(input pdm_t cur, input pdm_t tgt);
    if (cur < tgt) return cur + DISP_PDM_W'(1);
    if (cur > tgt) return cur - DISP_PDM_W'(1);
    return cur;
  endfunction

  logic              rise_p0;
  logic              gate_end_p0;
  logic [GATE_W-1:0] gate_cnt;
  lux_cnt_t          edge_cnt;
  lux_cnt_t          cnt_p1;
  logic              vld_p1;
  pdm_t              target_p2;
  logic              vld_p2;
  pdm_t              pdm_p3;

  // ---- stage 0: edge detect, gate timing, windowed edge count ----
  sync_rise u_sync_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (lux_in),
    .rise  (rise_p0)
  );

  assign gate_end_p0 = tsc_1ppus && (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (tsc_1ppus) begin
      gate_cnt <= (gate_cnt == GATE_LAST) ? '0 : gate_cnt + GATE_W'(1);
    end
  end

  // An edge landing on the closing cycle seeds the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (gate_end_p0) begin
      edge_cnt <= rise_p0 ? LUX_CNT_W'(1) : '0;
    end else if (rise_p0) begin
      edge_cnt <= sat_inc(edge_cnt);
    end
  end

  // ---- stage 1: publish closing count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= gate_end_p0;
      if (gate_end_p0) cnt_p1 <= edge_cnt;
    end
  end

  assign lux_cnt   = cnt_p1;
  assign lux_valid = vld_p1;

  // ---- stage 2: scale and clamp into a brightness target ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_p2 <= PDM_RESET;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) target_p2 <= clamp(sat_scale(cnt_p1), cfg_min, cfg_max);
    end
  end

  // ---- stage 3: brightness output (slewed in auto, direct in manual) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_p3 <= PDM_RESET;
    end else if (!cfg_auto) begin
      pdm_p3 <= cfg_manual;
    end else if (vld_p2) begin
      pdm_p3 <= slew(pdm_p3, target_p2);
    end
  end

  assign disp_pdm = pdm_p3;

endmodule

// File: tb/tb_disp_lux.sv
// Scoreboard bench for disp_lux: per-gate edge counts are queued as stimulus is
// planned and compared at lux_valid; brightness follows a reference slew model.
module tb_disp_lux;

  localparam int GATE  = 300;
  localparam int SH    = 0;
  localparam int TSC_P = 4;
  localparam int L     = GATE * TSC_P;
  localparam int NW    = 19;
  localparam int RST_W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tsc_1ppus;
  logic       lux_in;
  logic       cfg_auto;
  logic [7:0] cfg_manual;
  logic [7:0] cfg_min;
  logic [7:0] cfg_max;
  logic [7:0] disp_pdm;
  logic [15:0] lux_cnt;
  logic       lux_valid;

  disp_lux #(.GATE_US(GATE), .SHIFT(SH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tsc_1ppus  (tsc_1ppus),
    .lux_in     (lux_in),
    .cfg_auto   (cfg_auto),
    .cfg_manual (cfg_manual),
    .cfg_min    (cfg_min),
    .cfg_max    (cfg_max),
    .disp_pdm   (disp_pdm),
    .lux_cnt    (lux_cnt),
    .lux_valid  (lux_valid)
  );

  always #5 clk = ~clk;

  // Per-window plan: edges, boundary edge, and config applied mid-window.
  int t_n   [NW] = '{100, 100, 10, 20,  0,  0,  0, 280,   0, 280, 0, 0, 7, 7, 7, 7,  50,  60,  60};
  int t_b   [NW] = '{  0,   0,  1,  0,  0,  0,  0,   0,   0,   0, 0, 0, 0, 0, 0, 0,   0,   0,   0};
  int t_auto[NW] = '{  1,   1,  1,  1,  0,  1,  1,   1,   0,   1, 0, 1, 0, 1, 1, 1,   1,   1,   1};
  int t_man [NW] = '{  0,   0,  0,  0, 31,  0,  0,   0, 255,   0, 0, 0, 5, 5, 5, 5,   0,   0,   0};
  int t_min [NW] = '{ 16,  16, 16, 16,  0, 40, 40,  16,   0,  16, 0, 0, 0, 0, 0, 0,  16,  16,  16};
  int t_max [NW] = '{200, 200,200,200,255, 30, 30, 200, 255, 255, 0, 0,255,255,255,255,200, 200, 200};

  int n_chk  = 0;
  int n_pass = 0;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_target(input int cnt, input int lo, input int hi);
    int s;
    int t;
    s = cnt >> SH;
    if (s > 255) s = 255;
    t = (s < lo) ? lo : s;
    if (t > hi) t = hi;
    return t;
  endfunction

  function automatic int step_to(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  task automatic apply_cfg(input int w);
    cfg_auto   = (t_auto[w] != 0);
    cfg_manual = 8'(t_man[w]);
    cfg_min    = 8'(t_min[w]);
    cfg_max    = 8'(t_max[w]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pdm"},   32'(disp_pdm),  32'h80);
    chk({tag, "_cnt"},   32'(lux_cnt),   32'h0);
    chk({tag, "_valid"}, 32'(lux_valid), 32'h0);
  endtask

  initial begin
    int pdm_m;
    int pdm_nxt;
    int carry;
    int wsr;
    int e;
    logic lux_hi;

    rst_n     = 1'b0;
    tsc_1ppus = 1'b0;
    lux_in    = 1'b0;
    apply_cfg(0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n   = 1'b1;
    pdm_m   = 128;
    pdm_nxt = 128;
    carry   = 0;
    wsr     = 0;

    for (int w = 0; w < NW; w++) begin
      for (int pos = 0; pos < L; pos++) begin
        @(posedge clk);
        #1;
        if (pos == 0) begin
          chk("lux_valid_pulse", 32'(lux_valid), (wsr > 0) ? 32'd1 : 32'd0);
          if (wsr > 0) begin
            chk("lux_cnt_queued", 32'(q.size()), 32'd1);
            if (q.size() > 0) begin
              e = q.pop_front();
              chk("lux_cnt", 32'(lux_cnt), 32'(e));
              if (cfg_auto) pdm_nxt = step_to(pdm_m, exp_target(e, int'(cfg_min), int'(cfg_max)));
              else          pdm_nxt = int'(cfg_manual);
            end
          end
        end
        if (pos == 1) begin
          chk("lux_valid_single", 32'(lux_valid), 32'd0);
          chk("pdm_latency", 32'(disp_pdm), 32'(pdm_m));
        end
        if (pos == 2) begin
          pdm_m = pdm_nxt;
          chk("pdm_step", 32'(disp_pdm), 32'(pdm_m));
        end
        if (pos == 601) begin
          if (!cfg_auto) pdm_m = int'(cfg_manual);
          chk("pdm_cfg", 32'(disp_pdm), 32'(pdm_m));
        end
        if (pos == L - 1) chk("lux_valid_idle", 32'(lux_valid), 32'd0);

        tsc_1ppus = ((pos % TSC_P) == TSC_P - 1);
        lux_hi = (pos >= 8) && (pos < 8 + 4 * t_n[w]) && (((pos - 8) % 4) < 2);
        if (t_b[w] != 0 && (pos == L - 3 || pos == L - 2)) lux_hi = 1'b1;
        lux_in = lux_hi;
        if (pos == 600) apply_cfg(w);
        if (pos == L - 1) begin
          q.push_back(t_n[w] + carry);
          carry = t_b[w];
        end
        if (w == RST_W && pos == 700) begin
          lux_in    = 1'b0;
          tsc_1ppus = 1'b0;
          rst_n     = 1'b0;
          #2;
          chk_reset_vals("midgate_reset");
          @(posedge clk);
          @(posedge clk);
          #1;
          chk_reset_vals("held_reset");
          rst_n = 1'b1;
          q.delete();
          carry   = 0;
          pdm_m   = 128;
          pdm_nxt = 128;
          break;
        end
      end
      if (w == RST_W) wsr = 0;
      else            wsr++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/disp_lux.md
DISP_LUX -- requirements
Module: disp_lux

Interface
REQ-001 The parameter GATE_US SHALL default to 10000 and set the measurement gate length in tsc_1ppus pulses (microseconds).
REQ-002 The parameter SHIFT SHALL default to 4 and set the right-shift applied to the gate count to form a brightness value.
REQ-003 Port clk SHALL be an input, 1 bit wide, and the system clock (200 MHz).
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and the reset, asynchronous, active-low.
REQ-005 Port tsc_1ppus SHALL be an input, 1 bit wide, and a single-cycle strobe asserted once per microsecond.
REQ-006 Port lux_in SHALL be an input, 1 bit wide, and the asynchronous light-to-frequency sensor pulse train, at most clk/4.
REQ-007 Port cfg_auto SHALL be an input, 1 bit wide: 1 selects sensor-driven brightness, 0 selects manual brightness.
REQ-008 Port cfg_manual SHALL be an input, 8 bits wide, and the manual brightness level.
REQ-009 Port cfg_min SHALL be an input, 8 bits wide, and the lower clamp for the auto target.
REQ-010 Port cfg_max SHALL be an input, 8 bits wide, and the upper clamp for the auto target.
REQ-011 Port disp_pdm SHALL be an output, 8 bits wide, and the brightness fed to the display PDM dimmer; a higher value means brighter.
REQ-012 Port lux_cnt SHALL be an output, 16 bits wide, and the sensor edge count of the last completed gate.
REQ-013 Port lux_valid SHALL be an output, 1 bit wide, and a single-cycle pulse when lux_cnt updates.

Function
REQ-014 lux_in SHALL pass through a 2-FF synchronizer plus a 3rd FF, and a rising edge SHALL be detected on sync=1/prev=0.
REQ-015 The gate counter SHALL advance on each tsc_1ppus and wrap from GATE_US-1 to 0; gate_end SHALL be the cycle where tsc_1ppus is asserted with the count at GATE_US-1.
REQ-016 The edge counter (16 bits) SHALL increment on each detected edge and saturate at 0xFFFF without wrapping.
REQ-017 On gate_end the edge counter SHALL clear, to 1 if an edge is detected that same cycle and otherwise to 0; that edge belongs to the new window.
REQ-018 In the cycle after gate_end, lux_cnt SHALL load the closing count and lux_valid SHALL pulse for exactly one cycle.
REQ-019 Target computation SHALL take scaled = lux_cnt >> SHIFT, saturated to 255.
REQ-020 The target SHALL be max(scaled, cfg_min) followed by min(·, cfg_max); if cfg_min > cfg_max the target SHALL be cfg_max.
REQ-021 The target SHALL be registered in the cycle after lux_valid.
REQ-022 In auto mode, on the cycle after the target registers, disp_pdm SHALL step +1 if below the target, step -1 if above, and hold if equal; the step SHALL occur once per gate, with no over- or undershoot.
REQ-023 The auto-mode pipeline latency SHALL be: gate_end (cycle 0) -> lux_valid (1) -> target (2) -> disp_pdm step (3).
REQ-024 In manual mode (cfg_auto=0), disp_pdm SHALL equal cfg_manual registered with 1-cycle latency, with no slew.
REQ-025 Measurement (lux_cnt, lux_valid) SHALL continue while in manual mode.
REQ-026 On a manual->auto switch, the ramp SHALL start from the current disp_pdm with no jump.
REQ-027 Configuration changes SHALL take effect at the next target computation; a change mid-gate SHALL NOT reset the gate.
REQ-028 disp_pdm SHALL stay within 0..255 and never wrap at the 0/255 boundaries.

Reset
REQ-029 Reset SHALL be asynchronous assert and synchronous deassert via rst_n, with every flop in the rst_n/clk async reset style.
REQ-030 Reset values SHALL be: disp_pdm=8'h80, lux_cnt=0, lux_valid=0, target=8'h80, gate counter=0, edge counter=0, synchronizer flops=0.
REQ-031 Reset asserted mid-gate SHALL discard the partial count; the first lux_valid SHALL then come GATE_US microseconds after release.

Structure
REQ-032 The constants DISP_PDM_W=8 and LUX_CNT_W=16 SHALL live in the shared util_pkg and be used by this block and the display dimmer.
REQ-033 The sub-module sync_rise (2-FF synchronizer + rising-edge detect, single-cycle output) SHALL be instantiated once for lux_in.
REQ-034 All other logic SHALL be in disp_lux, targeting 150-250 lines of RTL.

Verification
REQ-035 Steady ramp: with 100 kHz lux_in, cfg_min=16, cfg_max=200 and auto mode -> lux_cnt=1000 (±1), target=62, disp_pdm falls 128->62 over 66 lux_valid pulses and then holds.
REQ-036 Saturation: with 10 MHz lux_in -> lux_cnt=0xFFFF, target=cfg_max=200, disp_pdm ramps up one per gate and stops at 200.
REQ-037 Clamp: with lux_in idle, cfg_min=40 and cfg_max=30 -> lux_cnt=0 and target=30 (inverted-clamp rule).
REQ-038 Gate boundary: an edge forced on the gate_end cycle -> counted in the next window, and lux_cnt of the closing window excludes it.
REQ-039 Mode switch: cfg_auto 1->0 with cfg_manual=5 -> disp_pdm=5 one cycle later; switching back to auto -> disp_pdm steps from 5 toward the target by 1 per gate.
REQ-040 Reset mid-gate: rst_n pulsed halfway through a gate -> all outputs return to reset values, and the next lux_valid arrives GATE_US microseconds after release.
